time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
Timekeeping and time-set controller for the VGA clock. It owns the BCD hours/minutes/seconds registers and advances them on a 1 s tick from an internal prescaler. It also generates the slow enable strobe that drives the button pulse generators, and it accepts their hour, minute and second adjust pulses, arbitrating them against the running tick. Downstream digit rendering reads the BCD outputs directly.

Parameters:
TICK_DIV, 31500000, clk cycles per seconds tick (must be >= 2)
BTN_DIV, 3150000, clk cycles per button enable strobe (must be >= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
adj_hrs  input  1  one-cycle hour adjust pulse
adj_mins  input  1  one-cycle minute adjust pulse
adj_secs  input  1  one-cycle second adjust pulse
btn_en  output  1  one-cycle strobe every BTN_DIV clocks; feeds the button pulse generators' clk_en
sec_tick  output  1  one-cycle strobe every TICK_DIV clocks
h_tens  output  2  hours tens digit, 0-2
h_units  output  4  hours units digit, 0-9
m_tens  output  3  minutes tens digit, 0-5
m_units  output  4  minutes units digit, 0-9
s_tens  output  3  seconds tens digit, 0-5
s_units  output  4  seconds units digit, 0-9

Behaviour:
- Reset: both prescalers go to 0 and pending is cleared. All digits are 0 (00:00:00). btn_en and sec_tick are 0 during reset and on the first cycle after it.
- Tick prescaler:
  - tick_cnt counts 0 to TICK_DIV-1 and then wraps to 0.
  - sec_tick = (tick_cnt == TICK_DIV-1), decoded combinationally from the register.
  - Width is $clog2(TICK_DIV).
- Button prescaler:
  - Independent counter, 0 to BTN_DIV-1.
  - btn_en = (btn_cnt == BTN_DIV-1).
  - Never stalls, and adjust activity does not affect it.
- Adjust arbitration, evaluated every cycle:
  - Priority is adj_hrs > adj_mins > adj_secs.
  - Only the winner is applied. Losers in the same cycle are dropped, not queued; the button generators re-issue them.
- Adjust actions (the time registers change at the clock edge that samples the pulse):
  - hrs: hours +1, wrapping 23 -> 00.
  - mins: minutes +1, wrapping 59 -> 00, no carry into hours.
  - secs: seconds +1, wrapping 59 -> 00, no carry into minutes.
- Tick action: seconds +1 with full carry chain.
  - 59 s -> 00 s and minutes +1.
  - 59 m -> 00 m and hours +1.
  - 23:59:59 -> 00:00:00.
- Digit arithmetic:
  - Units digit wraps 9 -> 0 and increments the tens digit.
  - Minutes/seconds tens wraps 5 -> 0.
  - Hours roll over when h_tens==2 and h_units==3, giving 0/0.
  - Hours 09 -> 10 and 19 -> 20 must both be correct.
- Tick/adjust collision (sec_tick and any adjust pulse in the same cycle):
  - The adjust is applied and the tick is deferred: pending <= 1.
  - On the next cycle with no adjust pulse, pending is applied as a tick and then cleared.
  - While pending=1, further adjust pulses continue to defer it.
  - A second sec_tick arriving while pending=1 does not stack: pending stays 1, and at most one tick is lost. This case is unreachable when TICK_DIV is much larger than BTN_DIV.
- Pending with no new tick: pending=1 with no adjust and no sec_tick applies one tick.
  - If sec_tick=1 and pending=1 with no adjust, exactly one tick is applied that cycle and pending clears; the tick is not applied twice.
- Reset mid-operation overrides everything on the cycle it is sampled, including pending and in-flight pulses.
- Illegal digit states cannot arise from reset or increments. No recovery logic is required.

Test Plan:
- Bench parameters: TICK_DIV=10, BTN_DIV=4.
- Reset for 3 cycles, release, run 40 cycles -> sec_tick high on cycles 9, 19, 29, 39 after release; btn_en on cycles 3, 7, 11, ...; time reads 00:00:04.
- Preload to 23:59:58 via adjusts, then 2 ticks -> 23:59:59, then 00:00:00 with all digits 0.
- adj_mins pulsed 60 times from 00:00:00 -> m wraps to 00 after 59, hours stay 00.
- adj_hrs pulsed 10, 20 and 24 times -> 10, 20, then 00.
- adj_hrs, adj_mins and adj_secs asserted together at 00:00:00 -> 01:00:00 only.
- adj_secs coincident with sec_tick at 00:00:05 -> 00:00:06 that edge, pending=1, 00:00:07 next cycle. With adj_secs held high for 3 cycles over the tick -> the tick is applied on the first adjust-free cycle.
- Assert reset while pending=1 at 12:34:56 -> 00:00:00, pending=0, no tick applied after release until tick_cnt reaches 9.

Source files
------------

// File: rtl/time_set_ctrl.sv
// BCD hours/minutes/seconds timekeeper with 1 s and button-enable prescalers.
// Adjust pulses (hrs > mins > secs) take priority over the running tick, which is deferred one slot.
module time_set_ctrl #(
   parameter int TICK_DIV = 31500000,
   parameter int BTN_DIV  = 3150000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       adj_hrs,
   input  logic       adj_mins,
   input  logic       adj_secs,
   output logic       btn_en,
   output logic       sec_tick,
   output logic [1:0] h_tens,
   output logic [3:0] h_units,
   output logic [2:0] m_tens,
   output logic [3:0] m_units,
   output logic [2:0] s_tens,
   output logic [3:0] s_units
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BTN_DIV > 1) ? $clog2(BTN_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BTN_LAST  = BW'(BTN_DIV - 1);

   logic [TW-1:0] r_tick_cnt;
   logic [BW-1:0] r_btn_cnt;
   logic          r_pending;
   logic [1:0]    r_h_tens;
   logic [3:0]    r_h_units;
   logic [2:0]    r_m_tens;
   logic [3:0]    r_m_units;
   logic [2:0]    r_s_tens;
   logic [3:0]    r_s_units;

   logic          w_adj_any;
   logic          w_s_wrap;
   logic          w_m_wrap;
   logic [1:0]    w_h_tens_inc;
   logic [3:0]    w_h_units_inc;
   logic [2:0]    w_m_tens_inc;
   logic [3:0]    w_m_units_inc;
   logic [2:0]    w_s_tens_inc;
   logic [3:0]    w_s_units_inc;

   assign sec_tick  = (r_tick_cnt == TICK_LAST);
   assign btn_en    = (r_btn_cnt == BTN_LAST);
   assign w_adj_any = adj_hrs | adj_mins | adj_secs;
   assign w_s_wrap  = (r_s_tens == 3'd5) && (r_s_units == 4'd9);
   assign w_m_wrap  = (r_m_tens == 3'd5) && (r_m_units == 4'd9);

   // Each field's "+1" value is computed once and shared by the adjust and tick paths.
   always_comb begin
      w_s_units_inc = r_s_units + 4'd1;
      w_s_tens_inc  = r_s_tens;
      if (r_s_units == 4'd9) begin
         w_s_units_inc = 4'd0;
         w_s_tens_inc  = (r_s_tens == 3'd5) ? 3'd0 : r_s_tens + 3'd1;
      end

      w_m_units_inc = r_m_units + 4'd1;
      w_m_tens_inc  = r_m_tens;
      if (r_m_units == 4'd9) begin
         w_m_units_inc = 4'd0;
         w_m_tens_inc  = (r_m_tens == 3'd5) ? 3'd0 : r_m_tens + 3'd1;
      end

      w_h_units_inc = r_h_units + 4'd1;
      w_h_tens_inc  = r_h_tens;
      if ((r_h_tens == 2'd2) && (r_h_units == 4'd3)) begin
         w_h_units_inc = 4'd0;
         w_h_tens_inc  = 2'd0;
      end else if (r_h_units == 4'd9) begin
         w_h_units_inc = 4'd0;
         w_h_tens_inc  = r_h_tens + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick_cnt <= '0;
         r_btn_cnt  <= '0;
         r_pending  <= 1'b0;
         r_h_tens   <= '0;
         r_h_units  <= '0;
         r_m_tens   <= '0;
         r_m_units  <= '0;
         r_s_tens   <= '0;
         r_s_units  <= '0;
      end else begin
         r_tick_cnt <= sec_tick ? '0 : r_tick_cnt + TW'(1);
         r_btn_cnt  <= btn_en ? '0 : r_btn_cnt + BW'(1);

         if (adj_hrs) begin
            r_h_tens  <= w_h_tens_inc;
            r_h_units <= w_h_units_inc;
         end else if (adj_mins) begin
            r_m_tens  <= w_m_tens_inc;
            r_m_units <= w_m_units_inc;
         end else if (adj_secs) begin
            r_s_tens  <= w_s_tens_inc;
            r_s_units <= w_s_units_inc;
         end

         // A deferred tick and a fresh tick in the same free cycle collapse into one.
         if (w_adj_any) begin
            if (sec_tick) r_pending <= 1'b1;
         end else if (sec_tick || r_pending) begin
            r_pending <= 1'b0;
            r_s_tens  <= w_s_tens_inc;
            r_s_units <= w_s_units_inc;
            if (w_s_wrap) begin
               r_m_tens  <= w_m_tens_inc;
               r_m_units <= w_m_units_inc;
               if (w_m_wrap) begin
                  r_h_tens  <= w_h_tens_inc;
                  r_h_units <= w_h_units_inc;
               end
            end
         end
      end
   end

   assign h_tens  = r_h_tens;
   assign h_units = r_h_units;
   assign m_tens  = r_m_tens;
   assign m_units = r_m_units;
   assign s_tens  = r_s_tens;
   assign s_units = r_s_units;

endmodule
